shared_divider: RTL and testbench

//  Multi-cycle unsigned restoring divider that serves the speed and average-speed blocks.
//  Two clients share it through a select line, and it answers them with a busy/ready handshake.
//  The client drives its operands while busy=0. The top level pulses start.
//  The client waits for busy=1, then for ready=1, and then reads result.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 27 ++
 rtl/shared_divider.sv | 140 ++++++++++++++
 tb/tb_shared_divider.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle restoring divider.
// DIV_ROUND_EN (in shared_divider) enables the ROUND state; the enum always reserves it.
package div_pkg;

  localparam int DIV_WIDTH = 16;

  // Wide all-ones pattern; users slice it down to their own WIDTH (up to 64 bits).
  localparam logic [63:0] DIV_ZERO_Q = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits, and report the quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] part_rem,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   new_rem,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The extra top bit keeps the carry of the shift so the compare is exact.
  assign shifted = {part_rem, next_bit};
  assign diff    = shifted - {1'b0, divisor};

  always_comb begin
    q_bit   = (shifted >= {1'b0, divisor});
    new_rem = q_bit ? diff : shifted;
  end

endmodule

// File: rtl/shared_divider.sv
// Two-client unsigned restoring divider with busy/ready handshake.
// Optional macro DIV_ROUND_EN adds a rounding state after the iterations.
module shared_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             select,
  input  logic [WIDTH-1:0] dividend0,
  input  logic [WIDTH-1:0] divisor0,
  input  logic [WIDTH-1:0] dividend1,
  input  logic [WIDTH-1:0] divisor1,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             owner
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ZERO_Q = DIV_ZERO_Q[WIDTH-1:0];

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH:0]   rem_reg;
  logic             dz_reg;

  logic             accept;
  logic [WIDTH-1:0] sel_dividend;
  logic [WIDTH-1:0] sel_divisor;
  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [WIDTH-1:0] quo_step;
  logic [1:0]       unused_bits;

  assign accept       = start && (state == IDLE || state == DONE);
  assign sel_dividend = select ? dividend1 : dividend0;
  assign sel_divisor  = select ? divisor1  : divisor0;
  assign quo_step     = {quo_reg[WIDTH-2:0], step_q};
  assign busy         = (state == CALC) || (state == ROUND);
  assign ready        = (state == DONE);
  // The partial remainder always stays below the divisor, so its top bit is never set.
  assign unused_bits  = {rem_reg[WIDTH], quo_reg[WIDTH-1]};

  div_step #(.WIDTH(WIDTH)) u_step (
    .part_rem (rem_reg[WIDTH-1:0]),
    .next_bit (dvd_reg[WIDTH-1]),
    .divisor  (dvs_reg),
    .new_rem  (step_rem),
    .q_bit    (step_q)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: state_next = accept ? CALC : IDLE;
      CALC: begin
        if (dz_reg) begin
          state_next = DONE;
        end else if (cnt == '0) begin
`ifdef DIV_ROUND_EN
          state_next = ROUND;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef DIV_ROUND_EN
      ROUND:   state_next = DONE;
`endif
      default: state_next = IDLE;
    endcase
  end

`ifdef DIV_ROUND_EN
  logic round_up;
  assign round_up = ({rem_reg[WIDTH-1:0], 1'b0} >= {1'b0, dvs_reg});
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt         <= '0;
      dvd_reg     <= '0;
      dvs_reg     <= '0;
      quo_reg     <= '0;
      rem_reg     <= '0;
      dz_reg      <= 1'b0;
      result      <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      owner       <= 1'b0;
    end else if (accept) begin
      dvd_reg     <= sel_dividend;
      dvs_reg     <= sel_divisor;
      dz_reg      <= (sel_divisor == '0);
      owner       <= select;
      div_by_zero <= 1'b0;
      cnt         <= CNT_W'(WIDTH - 1);
      quo_reg     <= '0;
      rem_reg     <= '0;
    end else if (state == CALC) begin
      if (dz_reg) begin
        result      <= ZERO_Q;
        remainder   <= dvd_reg;
        div_by_zero <= 1'b1;
      end else begin
        rem_reg <= step_rem;
        quo_reg <= quo_step;
        dvd_reg <= {dvd_reg[WIDTH-2:0], 1'b0};
        if (cnt != '0) cnt <= cnt - 1'b1;
`ifndef DIV_ROUND_EN
        if (cnt == '0) begin
          result    <= quo_step;
          remainder <= step_rem[WIDTH-1:0];
        end
`endif
      end
    end
`ifdef DIV_ROUND_EN
    else if (state == ROUND) begin
      // Round half up on the quotient; the reported remainder stays the truncated one.
      remainder <= rem_reg[WIDTH-1:0];
      result    <= (round_up && quo_reg != ZERO_Q) ? quo_reg + 1'b1 : quo_reg;
    end
`endif
  end

endmodule

// File: tb/tb_shared_divider.sv
// Scoreboard bench for shared_divider: stimulus pushes expectations, a monitor checks each ready.
module tb_shared_divider;

`ifdef DIV_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  localparam int LAT = RND ? 17 : 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        select = 1'b0;
  logic [15:0] dividend0 = '0, divisor0 = '0, dividend1 = '0, divisor1 = '0;
  logic        busy, ready, div_by_zero, owner;
  logic [15:0] result, remainder;

  shared_divider dut (
    .clk(clk), .rst(rst), .start(start), .select(select),
    .dividend0(dividend0), .divisor0(divisor0),
    .dividend1(dividend1), .divisor1(divisor1),
    .busy(busy), .ready(ready), .result(result), .remainder(remainder),
    .div_by_zero(div_by_zero), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        own;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding request.
  exp_t e;
  always @(posedge clk) begin
    #1;
    if (ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: got ready=1 expected no transaction at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        $display("txn %s: q=%0d r=%0d dz=%0b owner=%0b latency=%0d", e.name, result, remainder,
                 div_by_zero, owner, cyc - e.acc);
        check({e.name, "_result"}, 32'(result), 32'(e.q));
        check({e.name, "_remainder"}, 32'(remainder), 32'(e.r));
        check({e.name, "_dz"}, 32'(div_by_zero), 32'(e.dz));
        check({e.name, "_owner"}, 32'(owner), 32'(e.own));
        check({e.name, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  // Waits (bounded) for ready at falling edges, counting busy cycles on the way.
  task automatic wait_ready(input string name, output int busy_cnt);
    busy_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (ready) break;
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    if (!ready) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no ready expected ready within 60 cycles", name);
    end
  endtask

  // Called at a falling edge; issuing right after a ready exercises back-to-back starts.
  task automatic do_op(input string name, input bit sel,
                       input logic [15:0] a0, input logic [15:0] b0,
                       input logic [15:0] a1, input logic [15:0] b1,
                       input logic [15:0] eq, input logic [15:0] er,
                       input bit edz, input int busy_exp);
    int n;
    exp_t x;
    select = sel; dividend0 = a0; divisor0 = b0; dividend1 = a1; divisor1 = b1;
    start = 1'b1;
    @(posedge clk); #1;
    x.name = name; x.q = eq; x.r = er; x.dz = edz; x.own = sel; x.lat = busy_exp; x.acc = cyc;
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
    wait_ready(name, n);
    check({name, "_busy_cycles"}, 32'(n), 32'(busy_exp));
  endtask

  initial begin
    int n;
    exp_t x;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_owner", 32'(owner), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    do_op("t1_21600_360", 1'b0, 16'd21600, 16'd360, 16'd9, 16'd3, 16'd60, 16'd0, 1'b0, LAT);
    do_op("t2_1000_7", 1'b1, 16'd5, 16'd5, 16'd1000, 16'd7,
          RND ? 16'd143 : 16'd142, 16'd6, 1'b0, LAT);
    do_op("t3_div0", 1'b0, 16'd1234, 16'd0, 16'd8, 16'd2, 16'hFFFF, 16'd1234, 1'b1, 1);

    // Test 4: hammer start with changing operands while the divider is busy.
    select = 1'b0; dividend0 = 16'd50000; divisor0 = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    x.name = "t4_50000_3"; x.q = RND ? 16'd16667 : 16'd16666; x.r = 16'd2; x.dz = 1'b0;
    x.own = 1'b0; x.lat = LAT; x.acc = cyc;
    sb.push_back(x);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      start = 1'b1;
      select = i[0];
      dividend0 = 16'($urandom); divisor0 = 16'($urandom_range(0, 50));
      dividend1 = 16'($urandom); divisor1 = 16'($urandom_range(0, 50));
      @(negedge clk);
    end
    start = 1'b0;
    wait_ready("t4", n);
    @(negedge clk);
    check("t4_no_second_ready", 32'(ready), 32'd0);
    check("t4_idle_busy", 32'(busy), 32'd0);

    // Test 5: reset in the middle of a calculation aborts it silently.
    select = 1'b1; dividend1 = 16'd500; divisor1 = 16'd5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_busy_before_reset", 32'(busy), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_ready", 32'(ready), 32'd0);
    check("t5_rst_result", 32'(result), 32'd0);
    check("t5_rst_remainder", 32'(remainder), 32'd0);
    check("t5_rst_dz", 32'(div_by_zero), 32'd0);
    check("t5_rst_owner", 32'(owner), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    do_op("t5_100_10", 1'b0, 16'd100, 16'd10, 16'd0, 16'd0, 16'd10, 16'd0, 1'b0, LAT);

    do_op("t6_10_4", 1'b1, 16'd0, 16'd0, 16'd10, 16'd4,
          RND ? 16'd3 : 16'd2, 16'd2, 1'b0, LAT);
    do_op("t6_65535_1", 1'b0, 16'd65535, 16'd1, 16'd0, 16'd0, 16'd65535, 16'd0, 1'b0, LAT);
    do_op("t6_7_7", 1'b1, 16'd0, 16'd0, 16'd7, 16'd7, 16'd1, 16'd0, 1'b0, LAT);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
